// File: rtl/cnt_mod_updn_if.sv
// Control/status bundle for one cnt_mod_updn digit.
// The master side drives clear/load/enable/direction and observes the count;
// the slave side is the counter itself.
interface cnt_mod_updn_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output clr, load, din, en, up,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  clr, load, din, en, up,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/cnt_mod_updn.sv
// Modulo up/down counter with prescaler, synchronous clear, clamped parallel
// load, wrap or saturate behaviour at the boundaries, and cascade outputs.
// Multi-digit counters chain by feeding the next digit's en with en & tc.
// The interface instance must be built with the same WIDTH as this module.
module cnt_mod_updn #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rs,
  cnt_mod_updn_if.slave  bus
);

  // Prescaler needs at least one bit even when PRESCALE is 1.
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam bit               SAT      = (SATURATE != 0);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] cnt_step;
  logic [WIDTH-1:0] din_clamped;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nxt;
  logic             wrap_reg;
  logic             wrap_nxt;
  logic             ovf_reg;
  logic             ovf_nxt;
  logic             at_max;
  logic             at_zero;
  logic             tc;
  logic             step;

  assign at_max  = (cnt == Q_MAX);
  assign at_zero = (cnt == '0);

  // Terminal count looks only at the count and direction, so a cascade
  // reacts in the same cycle the low digit reaches its boundary.
  assign tc   = (bus.up & at_max) | (~bus.up & at_zero);
  assign step = bus.en & (pre == PRE_LAST);

  // Out-of-range load values are pulled back to the top of the range so the
  // count never leaves 0..MODULUS-1.
  assign din_clamped = (bus.din > Q_MAX) ? Q_MAX : bus.din;

  // Candidate next count for a step in either direction.
  always_comb begin
    cnt_inc = cnt + WIDTH'(1);
    cnt_dec = cnt - WIDTH'(1);
    if (at_max) begin
      cnt_inc = SAT ? cnt : '0;
    end
    if (at_zero) begin
      cnt_dec = SAT ? cnt : Q_MAX;
    end
    cnt_step = bus.up ? cnt_inc : cnt_dec;
  end

  // Next-state selection: clear beats load, load beats a step, otherwise hold.
  always_comb begin
    cnt_nxt  = cnt;
    pre_nxt  = pre;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf_reg;
    if (bus.clr) begin
      cnt_nxt = '0;
      pre_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      cnt_nxt = din_clamped;
      pre_nxt = '0;
    end else if (step) begin
      cnt_nxt = cnt_step;
      pre_nxt = '0;
      // A step taken at the boundary is flagged even when saturating and
      // the count itself does not move.
      if (tc) begin
        wrap_nxt = 1'b1;
        ovf_nxt  = 1'b1;
      end
    end else if (bus.en) begin
      pre_nxt = pre + PW'(1);
    end
  end

  // State registers; reset drops any partial prescale count.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      cnt      <= '0;
      pre      <= '0;
      wrap_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      pre      <= pre_nxt;
      wrap_reg <= wrap_nxt;
      ovf_reg  <= ovf_nxt;
    end
  end

  assign bus.q    = cnt;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_reg;
  assign bus.ovf  = ovf_reg;

  // The count must stay inside the modulus range.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rs) cnt <= Q_MAX);

  // A wrap pulse is always accompanied by the sticky flag.
  a_wrap_ovf: assert property (@(posedge clk) disable iff (!rs) wrap_reg |-> ovf_reg);

  // The prescaler never runs past its last phase.
  a_pre_range: assert property (@(posedge clk) disable iff (!rs) pre <= PRE_LAST);

endmodule

// File: tb/tb_cnt_mod_updn.sv
// Directed bench for cnt_mod_updn: wrap-mode digit, saturate-mode digit and
// a two-digit decimal cascade, checked through a scoreboard queue.
module tb_cnt_mod_updn;

  logic clk = 1'b0;
  logic rs  = 1'b1;

  always #5 clk = ~clk;

  cnt_mod_updn_if #(.WIDTH(4)) if_main ();
  cnt_mod_updn_if #(.WIDTH(4)) if_sat ();
  cnt_mod_updn_if #(.WIDTH(4)) if_lo ();
  cnt_mod_updn_if #(.WIDTH(4)) if_hi ();

  cnt_mod_updn #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_main (
    .clk(clk), .rs(rs), .bus(if_main)
  );
  cnt_mod_updn #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1)) u_sat (
    .clk(clk), .rs(rs), .bus(if_sat)
  );
  cnt_mod_updn #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_lo (
    .clk(clk), .rs(rs), .bus(if_lo)
  );
  cnt_mod_updn #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_hi (
    .clk(clk), .rs(rs), .bus(if_hi)
  );

  assign if_hi.en = if_lo.en & if_lo.tc;

  // dut: 0 = main, 1 = saturate, 2 = cascade ({hi.q, lo.q}, lo.tc, hi.wrap, hi.ovf)
  typedef struct {
    int    dut;
    string name;
    int    q;
    bit    tc;
    bit    wrap;
    bit    ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  event async_ev;

  task automatic expect_out(input int dut, input string name, input int q,
                            input bit tc, input bit wrap, input bit ovf);
    exp_t e;
    e.dut  = dut;
    e.name = name;
    e.q    = q;
    e.tc   = tc;
    e.wrap = wrap;
    e.ovf  = ovf;
    sb.push_back(e);
  endtask

  task automatic cyc(input int dut, input string name, input int q,
                     input bit tc, input bit wrap, input bit ovf);
    expect_out(dut, name, q, tc, wrap, ovf);
    @(negedge clk);
  endtask

  // Monitor: sample 1 time unit after each rising edge (or after an
  // asynchronous event) and compare against everything queued for that point.
  initial begin
    exp_t e;
    int   aq;
    bit   atc, aw, ao;
    forever begin
      @(posedge clk or async_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          0: begin
            aq = int'(if_main.q); atc = if_main.tc; aw = if_main.wrap; ao = if_main.ovf;
          end
          1: begin
            aq = int'(if_sat.q); atc = if_sat.tc; aw = if_sat.wrap; ao = if_sat.ovf;
          end
          default: begin
            aq = int'({if_hi.q, if_lo.q}); atc = if_lo.tc; aw = if_hi.wrap; ao = if_hi.ovf;
          end
        endcase
        checks++;
        if (aq != e.q || atc != e.tc || aw != e.wrap || ao != e.ovf) begin
          failures++;
          $display("FAIL %s @%0t: got q=%0h tc=%0b wrap=%0b ovf=%0b, expected q=%0h tc=%0b wrap=%0b ovf=%0b",
                   e.name, $time, aq, atc, aw, ao, e.q, e.tc, e.wrap, e.ovf);
        end
      end
    end
  end

  // Stimulus
  initial begin
    if_main.clr = 1'b0; if_main.load = 1'b0; if_main.din = 4'd0; if_main.en = 1'b0; if_main.up = 1'b0;
    if_sat.clr  = 1'b0; if_sat.load  = 1'b0; if_sat.din  = 4'd0; if_sat.en  = 1'b0; if_sat.up  = 1'b0;
    if_lo.clr   = 1'b0; if_lo.load   = 1'b0; if_lo.din   = 4'd0; if_lo.en   = 1'b0; if_lo.up   = 1'b0;
    if_hi.clr   = 1'b0; if_hi.load   = 1'b0; if_hi.din   = 4'd0; if_hi.up   = 1'b0;

    // Reset state, with up=0 so tc reads 1.
    #1 rs = 1'b0;
    #1;
    expect_out(0, "reset_main", 0, 1'b1, 1'b0, 1'b0);
    expect_out(1, "reset_sat", 0, 1'b1, 1'b0, 1'b0);
    expect_out(2, "reset_cascade", 0, 1'b1, 1'b0, 1'b0);
    -> async_ev;

    // Up count from reset: one step per 3 enabled cycles, 9 -> 0 at edge 30.
    @(negedge clk);
    rs = 1'b1;
    if_main.en = 1'b1;
    if_main.up = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      cyc(0, "up_wrap", (c / 3) % 10, ((c / 3) % 10) == 9, c == 30, c >= 30);
    end

    // Load clamp: 13 -> 9, prescaler restarts, ovf untouched.
    if_main.load = 1'b1; if_main.din = 4'd13;
    cyc(0, "load_clamp", 9, 1'b1, 1'b0, 1'b1);
    if_main.load = 1'b0;
    cyc(0, "load_pre1", 9, 1'b1, 1'b0, 1'b1);
    cyc(0, "load_pre2", 9, 1'b1, 1'b0, 1'b1);
    cyc(0, "load_first_step", 0, 1'b0, 1'b1, 1'b1);
    if_main.load = 1'b1; if_main.din = 4'd4;
    cyc(0, "load_din4", 4, 1'b0, 1'b0, 1'b1);
    if_main.load = 1'b0; if_main.en = 1'b0;
    cyc(0, "hold_en0", 4, 1'b0, 1'b0, 1'b1);

    // Priority: clr and load on a boundary stepping edge.
    if_main.load = 1'b1; if_main.din = 4'd9;
    cyc(0, "prio_load9", 9, 1'b1, 1'b0, 1'b1);
    if_main.load = 1'b0; if_main.en = 1'b1;
    cyc(0, "prio_pre1", 9, 1'b1, 1'b0, 1'b1);
    cyc(0, "prio_pre2", 9, 1'b1, 1'b0, 1'b1);
    if_main.clr = 1'b1; if_main.load = 1'b1; if_main.din = 4'd5;
    cyc(0, "prio_clr", 0, 1'b0, 1'b0, 1'b0);
    if_main.clr = 1'b0; if_main.load = 1'b0;
    cyc(0, "prio_pre1b", 0, 1'b0, 1'b0, 1'b0);
    cyc(0, "prio_pre2b", 0, 1'b0, 1'b0, 1'b0);
    if_main.load = 1'b1; if_main.din = 4'd3;
    cyc(0, "prio_load", 3, 1'b0, 1'b0, 1'b0);
    if_main.load = 1'b0;

    // Down count in wrap mode: 3,2,1,0 then 0 -> 9 at the 12th edge.
    if_main.up = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(0, "down_wrap", (13 - k / 3) % 10, ((13 - k / 3) % 10) == 0, k == 12, k >= 12);
    end

    // Direction change mid-prescale: the stepping edge's direction applies.
    cyc(0, "dir_pre1", 9, 1'b0, 1'b0, 1'b1);
    if_main.up = 1'b1;
    cyc(0, "dir_pre2", 9, 1'b1, 1'b0, 1'b1);
    cyc(0, "dir_step", 0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while q=7 with a partial prescale count pending.
    if_main.load = 1'b1; if_main.din = 4'd7;
    cyc(0, "pre_reset_load7", 7, 1'b0, 1'b0, 1'b1);
    if_main.load = 1'b0;
    cyc(0, "pre_reset_pre1", 7, 1'b0, 1'b0, 1'b1);
    if_main.en = 1'b0; if_main.up = 1'b0;
    #2 rs = 1'b0;
    expect_out(0, "async_reset", 0, 1'b1, 1'b0, 1'b0);
    -> async_ev;
    @(negedge clk);
    if_main.up = 1'b1;
    #2;
    expect_out(0, "reset_tc_up", 0, 1'b0, 1'b0, 1'b0);
    -> async_ev;
    @(negedge clk);
    rs = 1'b1; if_main.en = 1'b1;
    cyc(0, "discard_pre1", 0, 1'b0, 1'b0, 1'b0);
    cyc(0, "discard_pre2", 0, 1'b0, 1'b0, 1'b0);
    cyc(0, "discard_step", 1, 1'b0, 1'b0, 1'b0);
    if_main.en = 1'b0;

    // Saturate mode, counting down from 2 and holding at 0.
    if_sat.up = 1'b0; if_sat.load = 1'b1; if_sat.din = 4'd2;
    cyc(1, "sat_load2", 2, 1'b0, 1'b0, 1'b0);
    if_sat.load = 1'b0; if_sat.en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc(1, "sat_down", (k / 3 >= 2) ? 0 : 2 - k / 3, (k / 3 >= 2),
          (k >= 9) && (k % 3 == 0), k >= 9);
    end

    // Saturate mode, counting up from 8 and holding at 9.
    if_sat.up = 1'b1; if_sat.load = 1'b1; if_sat.din = 4'd8;
    cyc(1, "sat_load8", 8, 1'b0, 1'b0, 1'b1);
    if_sat.load = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1, "sat_up", (k >= 3) ? 9 : 8, k >= 3, (k >= 6) && (k % 3 == 0), 1'b1);
    end
    if_sat.en = 1'b0;

    // Two-digit decimal cascade: 00..99 then 00.
    if_lo.up = 1'b1; if_hi.up = 1'b1;
    if_lo.en = 1'b1;
    for (int c = 1; c <= 102; c++) begin
      cyc(2, "cascade", ((c % 100) / 10) * 16 + (c % 10), (c % 10) == 9, c == 100, c >= 100);
    end
    if_lo.en = 1'b0;

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
